// File: rtl/risc_pkg.sv
// Shared definitions for the accumulator CPU: widths, opcodes, phase encodings
// and the per-phase control word.
package risc_pkg;

  localparam int AWIDTH = 5;
  localparam int DWIDTH = 8;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
  } ctrl_t;

  // Opcodes that read an operand from memory into the accumulator path.
  function automatic logic is_alu(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      INST_ADDR:  return INST_FETCH;
      INST_FETCH: return INST_LOAD;
      INST_LOAD:  return IDLE;
      IDLE:       return OP_ADDR;
      OP_ADDR:    return OP_FETCH;
      OP_FETCH:   return ALU_OP;
      ALU_OP:     return STORE;
      default:    return INST_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/risc_memory.sv
// Unified program/data memory: synchronous write, combinational read.
module risc_memory #(
  parameter int AWIDTH = risc_pkg::AWIDTH,
  parameter int DWIDTH = risc_pkg::DWIDTH
) (
  input  logic              clk,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] array [0:(1<<AWIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr) array[addr] <= wdata;
  end

  assign rdata = rd ? array[addr] : '0;

endmodule

// File: rtl/risc_cpu.sv
// 8-bit accumulator CPU; every instruction walks the same eight phases, with
// controller, ALU, PC and address mux kept inline around the memory.
module risc_cpu #(
  parameter int AWIDTH = risc_pkg::AWIDTH,
  parameter int DWIDTH = risc_pkg::DWIDTH
) (
  input  logic clk,
  input  logic rst,
  output logic halt
);

  import risc_pkg::*;

  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] acc;
  phase_t            phase;
  ctrl_t             ctrl;

  logic [2:0]        opcode;
  logic [AWIDTH-1:0] operand;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] mem_data;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] alu_out;
  logic              zero;
  logic              is_hlt;
  logic              wr_en;

  assign opcode  = ir[DWIDTH-1 -: 3];
  assign operand = ir[AWIDTH-1:0];
  assign zero    = (acc == '0);
  assign is_hlt  = (opcode == HLT);
  assign addr    = ctrl.sel ? pc : operand;
  assign wdata   = ctrl.data_e ? acc : '0;
  // A reset landing on the STORE edge must not let the write through.
  assign wr_en   = ctrl.wr & rst;

  always_comb begin
    ctrl = '0;
    case (phase)
      INST_ADDR:  ctrl.sel = 1'b1;
      INST_FETCH: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        ctrl.sel   = 1'b1;
        ctrl.rd    = 1'b1;
        ctrl.ld_ir = 1'b1;
      end
      OP_ADDR:  ctrl.inc_pc = !is_hlt;
      OP_FETCH: ctrl.rd     = is_alu(opcode);
      ALU_OP: begin
        ctrl.rd     = is_alu(opcode);
        ctrl.inc_pc = (opcode == SKZ) && zero;
        ctrl.ld_pc  = (opcode == JMP);
        ctrl.data_e = (opcode == STO);
      end
      STORE: begin
        ctrl.rd     = is_alu(opcode);
        ctrl.ld_ac  = is_alu(opcode);
        ctrl.ld_pc  = (opcode == JMP);
        ctrl.wr     = (opcode == STO);
        ctrl.data_e = (opcode == STO);
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    alu_out = acc;
    case (opcode)
      ADD:     alu_out = acc + mem_data;
      AND:     alu_out = acc & mem_data;
      XOR:     alu_out = acc ^ mem_data;
      LDA:     alu_out = mem_data;
      default: alu_out = acc;
    endcase
  end

  // Halting parks the sequencer in OP_ADDR with every load disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= '0;
      ir    <= '0;
      acc   <= '0;
      phase <= INST_ADDR;
      halt  <= 1'b0;
    end else begin
      if (!(phase == OP_ADDR && is_hlt)) phase <= next_phase(phase);
      halt <= ((phase == IDLE) || (phase == OP_ADDR)) && is_hlt;
      if (ctrl.ld_ir) ir <= mem_data;
      if (ctrl.ld_pc)       pc <= operand;
      else if (ctrl.inc_pc) pc <= pc + 1'b1;
      if (ctrl.ld_ac) acc <= alu_out;
    end
  end

  risc_memory #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) memory_inst (
    .clk   (clk),
    .addr  (addr),
    .rd    (ctrl.rd),
    .wr    (wr_en),
    .wdata (wdata),
    .rdata (mem_data)
  );

endmodule

// File: tb/tb_risc_cpu.sv
// Bench for risc_cpu: directed program table, two hand-built corner cases and
// random programs scored against an instruction-level interpreter.
module tb_risc_cpu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt;

  int errors = 0;
  int checks = 0;

  logic [7:0] img     [0:31];
  logic [7:0] ref_mem [0:31];
  int         ref_halt_k;

  typedef struct {
    string       name;
    logic [95:0] prog;
    int          halt_edge;
    int          chk_addr;
    logic [7:0]  chk_val;
  } vec_t;

  vec_t vecs [7];

  risc_cpu dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt)
  );

  always #5 clk = ~clk;

  task automatic clock_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && dut.memory_inst.array[i] !== ref_mem[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s: mem[%0d] got %h, expected %h", name, bad,
               dut.memory_inst.array[bad], ref_mem[bad]);
    end
  endtask

  // Loads img while reset is held; the edge after loading is edge 0.
  task automatic apply_stimulus();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) dut.memory_inst.array[i] = img[i];
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Instruction-level interpreter: one loop iteration per executed instruction.
  task automatic run_model(input int max_k);
    logic [4:0] rpc;
    logic [7:0] racc, w;
    for (int i = 0; i < 32; i++) ref_mem[i] = img[i];
    rpc = 0;
    racc = 0;
    ref_halt_k = -1;
    for (int k = 0; k < max_k; k++) begin
      w = ref_mem[rpc];
      rpc = rpc + 5'd1;
      case (w[7:5])
        3'd0: begin ref_halt_k = k; return; end
        3'd1: if (racc == 0) rpc = rpc + 5'd1;
        3'd2: racc = racc + ref_mem[w[4:0]];
        3'd3: racc = racc & ref_mem[w[4:0]];
        3'd4: racc = racc ^ ref_mem[w[4:0]];
        3'd5: racc = ref_mem[w[4:0]];
        3'd6: ref_mem[w[4:0]] = racc;
        default: rpc = w[4:0];
      endcase
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  initial begin
    vecs[0] = '{"hlt",     96'h0,                         4,  0, 8'h00};
    vecs[1] = '{"jmp",     96'hE2E2,                      12, 0, 8'hE2};
    vecs[2] = '{"skz_z",   96'hE220,                      12, 0, 8'h20};
    vecs[3] = '{"lda_skz", 96'h0100000020A5,              20, 5, 8'h01};
    vecs[4] = '{"sto",     96'h000100000020A8C8A7,        36, 8, 8'h01};
    vecs[5] = '{"add_wrap", 96'h0100FF000000204B00204BA9, 44, 9, 8'hFF};
    vecs[6] = '{"and_xor", 96'h00FF3CF000000000CB8A69A8,  36, 11, 8'hCF};

    for (int v = 0; v < 7; v++) begin
      clear_img();
      for (int i = 0; i < 12; i++) img[i] = vecs[v].prog[i*8 +: 8];
      apply_stimulus();
      check_output({vecs[v].name, "_reset"}, {7'b0, halt}, 8'h00);
      clock_edges(vecs[v].halt_edge - 1);
      check_output({vecs[v].name, "_before"}, {7'b0, halt}, 8'h00);
      clock_edges(1);
      check_output({vecs[v].name, "_halt"}, {7'b0, halt}, 8'h01);
      clock_edges(5);
      check_output({vecs[v].name, "_hold"}, {7'b0, halt}, 8'h01);
      check_output({vecs[v].name, "_mem"}, dut.memory_inst.array[vecs[v].chk_addr], vecs[v].chk_val);
    end

    // PC wrap: JMP 31, SKZ at 31 skips over address 0, HLT at 1.
    clear_img();
    img[0] = 8'hFF;
    img[31] = 8'h20;
    apply_stimulus();
    clock_edges(19);
    check_output("wrap_before", {7'b0, halt}, 8'h00);
    clock_edges(1);
    check_output("wrap_halt", {7'b0, halt}, 8'h01);

    // Reset on the STORE edge of STO must suppress the write.
    clear_img();
    img[0] = 8'hC8;
    img[8] = 8'h55;
    apply_stimulus();
    clock_edges(7);
    rst = 1'b0;
    clock_edges(1);
    check_output("abort_mem", dut.memory_inst.array[8], 8'h55);
    check_output("abort_halt", {7'b0, halt}, 8'h00);
    rst = 1'b1;
    clock_edges(11);
    check_output("abort_rerun_before", {7'b0, halt}, 8'h00);
    clock_edges(1);
    check_output("abort_rerun_halt", {7'b0, halt}, 8'h01);
    check_output("abort_rerun_mem", dut.memory_inst.array[8], 8'h00);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
      run_model(40);
      apply_stimulus();
      if (ref_halt_k >= 0) begin
        clock_edges(8 * ref_halt_k + 3);
        check_output($sformatf("rand%0d_before", r), {7'b0, halt}, 8'h00);
        clock_edges(1);
        check_output($sformatf("rand%0d_halt", r), {7'b0, halt}, 8'h01);
        clock_edges(5);
        check_mem($sformatf("rand%0d_mem", r));
      end else begin
        clock_edges(320);
        check_output($sformatf("rand%0d_run", r), {7'b0, halt}, 8'h00);
        check_mem($sformatf("rand%0d_mem", r));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risc_cpu.md
Name: risc_cpu

Overview:
8-bit accumulator-based multi-cycle CPU with a unified 32x8 memory, 5-bit addresses and 3-bit opcodes. Every instruction takes exactly 8 clock phases. The only external output is halt. The CPU is the top of the processor subsystem. Program memory is preloaded by the bench through the hierarchical path memory_inst.array.

Parameters:
AWIDTH, 5, address width (memory depth 2**AWIDTH = 32)
DWIDTH, 8, data/instruction width

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  reset; synchronous and active-low
halt  output  1  high while a HLT instruction is at or past its decode phase

Behaviour:
- Instruction word: [7:5] opcode, [4:0] operand address.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- State: PC (5b), IR (8b), ACC (8b), phase counter (3b). All registers are updated on the rising clk edge.
- Reset (rst==0 at a clk edge):
  - PC=0, IR=0, ACC=0, phase=0; halt deasserts.
  - Memory contents are not touched by reset.
- Phases and controls (sel selects PC as the memory address, otherwise IR[4:0]):
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: inc_pc. halt is asserted if the opcode is HLT.
  - 5 OP_FETCH: rd if the opcode is ALU-class (ADD, AND, XOR, LDA).
  - 6 ALU_OP: rd if ALU-class; inc_pc if SKZ and ACC==0; ld_pc if JMP; data drive if STO.
  - 7 STORE: rd and ld_ac if ALU-class; ld_pc if JMP; wr and data drive if STO.
- PC behaviour:
  - ld_pc loads IR[4:0].
  - inc_pc adds 1, wrapping 31 to 0.
  - SKZ therefore skips exactly one instruction without costing extra cycles.
- ALU result:
  - ADD: ACC+mem, mod 256, carry discarded.
  - AND: ACC&mem. XOR: ACC^mem. LDA: mem.
  - Any other opcode: passes ACC unchanged.
- The zero flag is combinational (ACC==0).
- Memory:
  - Instance memory_inst, array named array[0:31] of DWIDTH bits.
  - Write is synchronous on wr.
  - Read is combinational from the muxed address.
- Timing:
  - The phase counter runs 0..7 and wraps.
  - Counting the reset edge as edge 0, instruction k (k-th executed, 0-based) asserts halt after edge 8k+4 if it is HLT.
  - For the first instruction, halt is 0 after edges 1..3 and 1 after edge 4.
- After halt:
  - The phase counter freezes at 4 and halt stays 1.
  - No further register or memory updates occur until rst goes low.
- Reset mid-instruction aborts the instruction; a pending STO write in phase 7 is suppressed.
- Undefined (x) operand bits in HLT/SKZ words must not affect behaviour.

Decomposition:
- Package risc_pkg holds:
  - the opcode localparams (HLT..JMP)
  - the phase encodings (INST_ADDR..STORE)
  - AWIDTH and DWIDTH defaults
- Sub-module risc_memory (instance name memory_inst, array "array") is required.
- Controller, ALU, PC counter, address mux and registers are kept inline in risc_cpu.

Test Plan:
- HLT at address 0; pulse rst low for one edge, then clock high. Halt=0 after 3 more edges and halt=1 after the 4th; halt stays 1 for 5 further clocks.
- JMP:
  - Program: mem0=JMP 2, mem1=JMP 2, mem2=HLT.
  - Reset, then 11 edges: halt=0. 12th edge: halt=1.
- SKZ with ACC=0 after reset:
  - Program: mem0=SKZ, mem1=JMP 2, mem2=HLT.
  - halt=1 exactly at edge 12.
- LDA/SKZ non-zero:
  - Program: mem0=LDA 5, mem1=SKZ, mem2=HLT, mem5=1.
  - halt=0 through edge 19; halt=1 at edge 20.
- STO round trip:
  - Program: LDA 7 (mem7=1), STO 8, LDA 8, SKZ, HLT at 4.
  - halt=1 at edge 36; mem8 reads 1.
- ADD wraparound:
  - Program: LDA 9 (ff), ADD 11 (01) gives 00, SKZ skips HLT at 3; ADD 11 gives 01, SKZ does not skip, HLT at 6.
  - halt=0 through edge 43; halt=1 at edge 44.
